bs_frame_sched: RTL and testbench

- Scheduler that frames and issues word-serial operations into the bit-serial modular-multiplier datapath.
- Generates the word-start sync pulse and bit index for each operand frame.
- Credit-limits frames in flight, counts returned output syncs, and signals completion of a batch of NOPS operations.
- Sits between the host/control FSM and the chain of bit-serial stages (splitters, adders, modmul core).

---
 rtl/bs_pkg.sv | 34 +++
 rtl/bs_credit_cnt.sv | 61 ++++++
 rtl/bs_frame_sched.sv | 209 ++++++++++++++++++++
 tb/tb_bs_frame_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// -----------------------------------------------------------------------------
// bs_pkg
// Definitions shared by the bit-serial frame scheduler and its helpers.
//   bs_state_e : scheduler FSM states (IDLE, ISSUE, GAPW, DRAIN)
//   bs_cnt_w   : width needed for a counter that holds values 0..maxval
//   bs_gap_load: reload value of the inter-frame gap counter
// -----------------------------------------------------------------------------
package bs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAPW  = 2'd2,
        ST_DRAIN = 2'd3
    } bs_state_e;

    // The gap-wait state always lasts at least one cycle, even when no
    // inter-frame gap is configured (it is also where credit stalls wait).
    localparam int BS_MIN_GAP = 1;

    // Bits needed to hold 0..maxval (never less than one bit).
    function automatic int bs_cnt_w(input int maxval);
        if (maxval < 2) begin
            return 1;
        end
        return $clog2(maxval + 1);
    endfunction

    // Number of gap-wait cycles after a frame when GAP cycles are requested.
    function automatic int bs_gap_load(input int gap);
        return (gap < BS_MIN_GAP) ? BS_MIN_GAP : gap;
    endfunction

endpackage

// File: rtl/bs_credit_cnt.sv
// -----------------------------------------------------------------------------
// bs_credit_cnt
// Up/down saturating counter of frames in flight, reusable by any bit-serial
// stage controller that needs credit accounting.
//   clk         : clock, rising edge
//   srst_i      : synchronous active-high reset, clears the count
//   inc_i       : one frame issued this cycle (ignored when already at MAXV)
//   dec_i       : one frame returned this cycle (ignored when count is 0)
//   count_o     : registered count of frames in flight
//   settle_o    : count after this cycle's return, before this cycle's issue;
//                 callers use it to decide credit and drain completion
//   underflow_o : dec_i arrived while the count was already 0
// A simultaneous inc/dec leaves the count unchanged.
// -----------------------------------------------------------------------------
module bs_credit_cnt #(
    parameter int MAXV = 4,
    parameter int W    = 3
) (
    input  logic         clk,
    input  logic         srst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] settle_o,
    output logic         underflow_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] settle;
    logic         underflow;

    always_comb begin
        underflow = dec_i && (count_q == '0);

        // Apply the return first so that a frame returning this cycle frees
        // its slot for a frame issued in the same cycle.
        settle = count_q;
        if (dec_i && !underflow) begin
            settle = count_q - W'(1);
        end

        count_d = settle;
        if (inc_i && (settle < W'(MAXV))) begin
            count_d = settle + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign settle_o    = settle;
    assign underflow_o = underflow;

endmodule

// File: rtl/bs_frame_sched.sv
// -----------------------------------------------------------------------------
// bs_frame_sched
// Frames word-serial operations into the bit-serial modular-multiplier chain.
// A batch of nops frames is issued, each WORDLEN cycles long, optionally
// separated by GAP idle cycles, while at most MAXOUT frames may be in flight
// (issued but whose output sync has not come back yet).
//
// Ports (all outputs registered):
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset; aborts any batch
//   start       in   begin a batch; only taken in IDLE while not busy
//   nops        in   frames in the batch, captured with start
//   busy        out  cycle after accepted start through the done cycle
//   done        out  one-cycle pulse when the batch has fully returned
//   isync       out  pulse on the first bit of every issued frame
//   bitidx      out  WORDLEN-1 on isync, counting down to 0; 0 between frames
//   osync_ret   in   one pulse per frame leaving the datapath tail
//   outstanding out  frames issued minus frames returned
//   err         out  sticky: a return arrived with nothing outstanding;
//                    cleared by an accepted start or reset
// -----------------------------------------------------------------------------
module bs_frame_sched
    import bs_pkg::*;
#(
    parameter int WORDLEN  = 16,
    parameter int LOG2WORD = 5,
    parameter int MAXOUT   = 4,
    parameter int LOG2OUT  = 3,
    parameter int GAP      = 0,
    parameter int CNTW     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNTW-1:0]     nops,
    output logic                busy,
    output logic                done,
    output logic                isync,
    output logic [LOG2WORD-1:0] bitidx,
    input  logic                osync_ret,
    output logic [LOG2OUT-1:0]  outstanding,
    output logic                err
);

    localparam int GAP_LOAD = bs_gap_load(GAP);
    localparam int GAP_W    = bs_cnt_w(GAP_LOAD);

    bs_state_e state_q;
    bs_state_e state_d;

    logic [CNTW-1:0]     remaining_q;
    logic [CNTW-1:0]     remaining_d;
    logic [LOG2WORD-1:0] bitidx_q;
    logic [LOG2WORD-1:0] bitidx_d;
    logic [GAP_W-1:0]    gap_q;
    logic [GAP_W-1:0]    gap_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                isync_q;
    logic                isync_d;
    logic                err_q;
    logic                err_d;

    logic                accept;
    logic                issue;
    logic                credit_ok;
    logic                underflow;
    logic [LOG2OUT-1:0]  out_count;
    logic [LOG2OUT-1:0]  out_settle;

    // -------------------------------------------------------------------------
    // Frames in flight
    // -------------------------------------------------------------------------
    bs_credit_cnt #(
        .MAXV (MAXOUT),
        .W    (LOG2OUT)
    ) u_credit (
        .clk         (clk),
        .srst_i      (reset),
        .inc_i       (issue),
        .dec_i       (osync_ret),
        .count_o     (out_count),
        .settle_o    (out_settle),
        .underflow_o (underflow)
    );

    // A return registered this cycle already frees its slot for the frame
    // that would start next cycle.
    assign credit_ok = (out_settle < LOG2OUT'(MAXOUT));

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bitidx_d    = '0;
        gap_d       = gap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        isync_d     = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // busy_q is still high in the done cycle (state already
                // IDLE), which is what makes a start there get ignored.
                if (start && !busy_q) begin
                    accept      = 1'b1;
                    busy_d      = 1'b1;
                    remaining_d = nops;
                    if (nops == '0) begin
                        done_d = 1'b1;
                    end else if (credit_ok) begin
                        issue   = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        gap_d   = GAP_W'(BS_MIN_GAP);
                        state_d = ST_GAPW;
                    end
                end
            end

            ST_ISSUE: begin
                if (bitidx_q != '0) begin
                    bitidx_d = bitidx_q - LOG2WORD'(1);
                end else if (remaining_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (GAP > 0) begin
                    gap_d   = GAP_W'(GAP_LOAD);
                    state_d = ST_GAPW;
                end else if (credit_ok) begin
                    // Back-to-back frame: the next isync follows bit 0.
                    issue = 1'b1;
                end else begin
                    gap_d   = GAP_W'(BS_MIN_GAP);
                    state_d = ST_GAPW;
                end
            end

            ST_GAPW: begin
                // The counter holds at 1 once the gap has elapsed, so the
                // state then simply waits for credit.
                if (gap_q > GAP_W'(1)) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (credit_ok) begin
                    issue   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_DRAIN: begin
                if (out_settle == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue) begin
            isync_d     = 1'b1;
            bitidx_d    = LOG2WORD'(WORDLEN - 1);
            remaining_d = remaining_d - CNTW'(1);
        end

        err_d = (accept ? 1'b0 : err_q) | underflow;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            bitidx_q    <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            isync_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bitidx_q    <= bitidx_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            isync_q     <= isync_d;
            err_q       <= err_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign isync       = isync_q;
    assign bitidx      = bitidx_q;
    assign outstanding = out_count;
    assign err         = err_q;

endmodule

// File: tb/tb_bs_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_bs_frame_sched
// Two schedulers side by side: A with the default configuration (MAXOUT=4,
// GAP=0) and B with MAXOUT=1, GAP=2. Each one's datapath returns are modelled
// by a booking table filled whenever the reference predicts an isync. The
// reference works in terms of frame start times: a frame starts at the first
// cycle that is no earlier than the previous start + WORDLEN + GAP and whose
// preceding cycle leaves fewer than MAXOUT frames in flight.
// -----------------------------------------------------------------------------
module tb_bs_frame_sched;

    localparam int WL   = 16;
    localparam int MAXC = 8000;

    typedef struct packed {
        int maxout;
        int gap;
        bit act;       // batch accepted and not yet done
        int left;      // frames not yet started
        int fs;        // start cycle of the latest frame
        int earliest;  // earliest cycle the next frame may start
        int out;
        bit busy;
        bit done;
        bit err;
        bit isync;
        int bitidx;
    } mdl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] nops_a, nops_b;
    logic       ret_a, ret_b;
    logic       busy_a, done_a, isync_a, err_a;
    logic       busy_b, done_b, isync_b, err_b;
    logic [4:0] bitidx_a, bitidx_b;
    logic [2:0] outstanding_a;
    logic [0:0] outstanding_b;

    always #5 clk = ~clk;

    bs_frame_sched u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .nops        (nops_a),
        .busy        (busy_a),
        .done        (done_a),
        .isync       (isync_a),
        .bitidx      (bitidx_a),
        .osync_ret   (ret_a),
        .outstanding (outstanding_a),
        .err         (err_a)
    );

    bs_frame_sched #(
        .MAXOUT  (1),
        .LOG2OUT (1),
        .GAP     (2)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .nops        (nops_b),
        .busy        (busy_b),
        .done        (done_b),
        .isync       (isync_b),
        .bitidx      (bitidx_b),
        .osync_ret   (ret_b),
        .outstanding (outstanding_b),
        .err         (err_b)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   dly_lo, dly_hi;
    bit   spur_a, spur_b;
    bit   sched [2][MAXC];
    mdl_t ma, mb;
    int   peak_a, peak_b, ndone_a;
    int   last_isync_b = 0;
    int   prev_isync_b = 0;

    // Predict the outputs of cycle c+1 from the picture at cycle c.
    function automatic mdl_t mstep(input mdl_t m, input int c, input bit rst,
                                   input bit st, input int n, input bit ret);
        mdl_t r;
        bit   acc;
        bit   issue;
        bit   fin;
        int   settle;
        r = m;
        if (rst) begin
            r.act = 0; r.left = 0; r.fs = -1000; r.earliest = 0; r.out = 0;
            r.busy = 0; r.done = 0; r.err = 0; r.isync = 0; r.bitidx = 0;
            return r;
        end
        settle = m.out - ((ret && m.out > 0) ? 1 : 0);
        acc    = st && !m.act && !m.busy;
        issue  = 0;
        fin    = 0;
        if (acc) begin
            r.left = n;
            if (n == 0) begin
                fin = 1;
            end else begin
                r.act      = 1;
                r.earliest = c + 1;
                issue      = (settle < m.maxout);
            end
        end else if (m.act) begin
            if (m.left > 0)
                issue = (c + 1 >= m.earliest) && (settle < m.maxout);
            else
                fin = (c >= m.fs + WL) && (settle == 0);
        end
        if (issue) begin
            r.left     = r.left - 1;
            r.fs       = c + 1;
            r.earliest = c + 1 + WL + m.gap;
        end
        if (fin) begin
            r.act = 0; r.done = 1; r.busy = 1;
        end else begin
            r.done = 0; r.busy = r.act;
        end
        r.out    = m.out + (issue ? 1 : 0) - ((ret && m.out > 0) ? 1 : 0);
        r.err    = (acc ? 1'b0 : m.err) | (ret && m.out == 0);
        r.isync  = issue;
        r.bitidx = (c + 1 >= r.fs && c + 1 < r.fs + WL) ? (WL - 1 - (c + 1 - r.fs)) : 0;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic book(input int i, input int t);
        int s;
        s = t;
        while (s < MAXC - 1 && sched[i][s]) s++;
        sched[i][s] = 1'b1;
    endtask

    task automatic tick();
        mdl_t na, nb;
        ret_a = sched[0][cyc] | spur_a;
        ret_b = sched[1][cyc] | spur_b;
        na = mstep(ma, cyc, reset, start_a, int'(nops_a), ret_a);
        nb = mstep(mb, cyc, reset, start_b, int'(nops_b), ret_b);
        if (na.isync) book(0, cyc + 1 + int'($urandom_range(dly_hi, dly_lo)));
        if (nb.isync) book(1, cyc + 1 + int'($urandom_range(dly_hi, dly_lo)));
        @(posedge clk);
        #1;
        cyc++;
        ma = na;
        mb = nb;
        start_a = 1'b0; start_b = 1'b0; spur_a = 1'b0; spur_b = 1'b0;
        if (int'(outstanding_a) > peak_a) peak_a = int'(outstanding_a);
        if (int'(outstanding_b) > peak_b) peak_b = int'(outstanding_b);
        if (done_a === 1'b1) ndone_a++;
        if (isync_b === 1'b1) begin
            prev_isync_b = last_isync_b;
            last_isync_b = cyc;
        end
        chk("a_busy",   32'(busy_a),        32'(ma.busy));
        chk("a_done",   32'(done_a),        32'(ma.done));
        chk("a_isync",  32'(isync_a),       32'(ma.isync));
        chk("a_bitidx", 32'(bitidx_a),      32'(ma.bitidx));
        chk("a_out",    32'(outstanding_a), 32'(ma.out));
        chk("a_err",    32'(err_a),         32'(ma.err));
        chk("b_busy",   32'(busy_b),        32'(mb.busy));
        chk("b_done",   32'(done_b),        32'(mb.done));
        chk("b_isync",  32'(isync_b),       32'(mb.isync));
        chk("b_bitidx", 32'(bitidx_b),      32'(mb.bitidx));
        chk("b_out",    32'(outstanding_b), 32'(mb.out));
        chk("b_err",    32'(err_b),         32'(mb.err));
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((ma.act || ma.busy || mb.act || mb.busy) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; nops_a = '0; nops_b = '0;
        spur_a = 1'b0; spur_b = 1'b0; ret_a = 1'b0; ret_b = 1'b0;
        dly_lo = 20; dly_hi = 20;
        ma = '0; mb = '0;
        ma.maxout = 4; ma.gap = 0; ma.fs = -1000;
        mb.maxout = 1; mb.gap = 2; mb.fs = -1000;

        // Reset state
        tick_n(3);
        reset = 1'b0;
        tick_n(2);

        // Single frame, return 20 cycles after isync
        start_a = 1'b1; nops_a = 8'd1;
        tick();
        run_idle(200);
        tick_n(3);

        // Three back-to-back frames, returns 40 cycles late
        peak_a = 0; ndone_a = 0; dly_lo = 40; dly_hi = 40;
        start_a = 1'b1; nops_a = 8'd3;
        tick();
        run_idle(300);
        chk("s2_peak_out", 32'(peak_a), 32'd3);
        chk("s2_done_cnt", 32'(ndone_a), 32'd1);

        // Single credit: frames wait for each return
        peak_b = 0; dly_lo = 20; dly_hi = 20;
        start_b = 1'b1; nops_b = 8'd3;
        tick();
        run_idle(300);
        chk("s3_peak_out_b", 32'(peak_b), 32'd1);

        // Fast returns: spacing between isyncs is WORDLEN + GAP
        dly_lo = 5; dly_hi = 5;
        start_b = 1'b1; nops_b = 8'd2;
        tick();
        run_idle(300);
        chk("s4_isync_spacing", 32'(last_isync_b - prev_isync_b), 32'd18);

        // Empty batch on both
        ndone_a = 0;
        start_a = 1'b1; nops_a = 8'd0; start_b = 1'b1; nops_b = 8'd0;
        tick();
        tick_n(3);
        chk("s5_done_cnt", 32'(ndone_a), 32'd1);

        // Return with nothing outstanding, then a start clears err
        spur_a = 1'b1; spur_b = 1'b1;
        tick();
        tick_n(5);
        dly_lo = 20; dly_hi = 20;
        start_a = 1'b1; nops_a = 8'd2;
        tick();
        tick_n(5);
        start_a = 1'b1; nops_a = 8'd7;   // ignored while busy
        tick();
        run_idle(300);

        // Reset in the middle of the second frame
        dly_lo = 40; dly_hi = 40;
        start_a = 1'b1; nops_a = 8'd5;
        tick();
        n = 0;
        while (!(ma.bitidx == 7 && ma.out == 2) && n < 100) begin
            tick();
            n++;
        end
        chk("s6_reach_midframe", 32'(n < 100), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick_n(60);
        dly_lo = 20; dly_hi = 20;
        start_a = 1'b1; nops_a = 8'd1;
        tick();
        run_idle(200);
        tick_n(3);

        // Randomised traffic
        dly_lo = 10; dly_hi = 60;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                start_a = 1'b1;
                nops_a  = 8'($urandom_range(6, 0));
            end
            if ($urandom_range(7, 0) == 0) begin
                start_b = 1'b1;
                nops_b  = 8'($urandom_range(4, 0));
            end
            if (!ma.act && !ma.busy && !sched[0][cyc] && $urandom_range(39, 0) == 0)
                spur_a = 1'b1;
            if (!mb.act && !mb.busy && !sched[1][cyc] && $urandom_range(39, 0) == 0)
                spur_b = 1'b1;
            tick();
        end
        run_idle(2000);
        tick_n(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
